// File: rtl/spi_cfg_pkg.sv
// Shared constants, slot positions and FSM states for the SPI decoder.
// No ports: imported by the decoder and its bench.
package spi_cfg_pkg;

  localparam logic [2:0] IDX_CTRL = 3'b000;
  localparam logic [2:0] IDX_DAC  = 3'b001;
  localparam logic [2:0] IDX_PUSH = 3'b111;

  localparam logic [3:0] SLOT_RW         = 4'd1;
  localparam logic [3:0] SLOT_IDX_LAST   = 4'd4;
  localparam logic [3:0] SLOT_RDATA_LOAD = 4'd6;
  localparam logic [3:0] SLOT_WDATA_LAST = 4'd13;
  localparam logic [3:0] SLOT_LAST       = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_HDR,
    S_WDATA,
    S_RDATA,
    S_WAIT,
    S_ERR
  } state_t;

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Register-file side bus of the SPI decoder: write strobe, read request.
// master = decoder (drives wr_*, rd_req, rd_index; takes rd_data).
interface spi_cmd_decoder_if;

  logic       wr_en;
  logic [2:0] wr_index;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [2:0] rd_index;
  logic [7:0] rd_data;

  modport master (
    output wr_en,
    output wr_index,
    output wr_data,
    output rd_req,
    output rd_index,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_index,
    input  wr_data,
    input  rd_req,
    input  rd_index,
    output rd_data
  );

endinterface

// File: rtl/spi_sdo_serializer.sv
// MISO shifter: sync pattern first, rd_data spliced in behind it, MSB first.
// Ports: clk, rst, clear, sync_load, data_load, shift, rd_data -> sdo.
module spi_sdo_serializer #(
  parameter logic [2:0] SYNC_PATTERN = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       sync_load,
  input  logic       data_load,
  input  logic       shift,
  input  logic [7:0] rd_data,
  output logic       sdo
);

  // Bits still to be driven, next one at the top.
  logic [9:0] pend;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pend <= '0;
      sdo  <= 1'b0;
    end else if (sync_load) begin
      pend <= {SYNC_PATTERN[1:0], 8'h00};
      sdo  <= SYNC_PATTERN[2];
    end else if (data_load) begin
      // Last sync bit goes out now; rd_data arrives just in time behind it.
      pend <= {rd_data, 2'b00};
      sdo  <= pend[9];
    end else if (shift) begin
      pend <= {pend[8:0], 1'b0};
      sdo  <= pend[9];
    end
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI frame decoder: 16-bit frames -> write strobes / read requests.
// Ports: clk_40MHz, rst, spi_cs/sdi/sdo, bus (master), frame_err_cnt, busy.
module spi_cmd_decoder
  import spi_cfg_pkg::*;
#(
  parameter logic [2:0] SYNC_PATTERN = 3'b101,
  parameter int         ERR_CNT_W    = 8
) (
  input  logic                 clk_40MHz,
  input  logic                 rst,
  input  logic                 spi_cs,
  input  logic                 spi_sdi,
  output logic                 spi_sdo,
  spi_cmd_decoder_if.master    bus,
  output logic [ERR_CNT_W-1:0] frame_err_cnt,
  output logic                 busy
);

  logic       cs_q;
  logic       sdi_q;
  logic [3:0] slot;

  state_t     state;
  state_t     state_nx;
  state_t     cur;

  logic       rw;
  logic       rw_nx;
  logic [2:0] idx;
  logic [2:0] idx_nx;
  logic [7:0] data;
  logic [7:0] data_nx;
  logic       wr_en_nx;
  logic       rd_req_nx;
  logic       err_inc;

  always_ff @(posedge clk_40MHz) begin
    cs_q  <= spi_cs;
    sdi_q <= spi_sdi;
  end

  // Slot number of the current cs_q-low cycle.
  always_ff @(posedge clk_40MHz) begin
    if (rst || cs_q) begin
      slot <= '0;
    end else if (slot != SLOT_LAST) begin
      slot <= slot + 4'd1;
    end
  end

  always_comb begin
    // IDLE only sees cs_q low on a fresh falling edge: that cycle is slot 0.
    cur       = (state == S_IDLE && !cs_q) ? S_START : state;
    state_nx  = cur;
    rw_nx     = rw;
    idx_nx    = idx;
    data_nx   = data;
    wr_en_nx  = 1'b0;
    rd_req_nx = 1'b0;
    err_inc   = 1'b0;
    unique case (cur)
      S_IDLE: begin
        state_nx = S_IDLE;
      end
      S_START: begin
        if (sdi_q) begin
          state_nx = S_HDR;
        end else begin
          state_nx = S_ERR;
          err_inc  = 1'b1;
        end
      end
      S_HDR: begin
        if (cs_q) begin
          state_nx = S_IDLE;
          err_inc  = 1'b1;
        end else begin
          if (slot == SLOT_RW) begin
            rw_nx = sdi_q;
          end else begin
            idx_nx = {idx[1:0], sdi_q};
          end
          if (slot == SLOT_IDX_LAST) begin
            if (rw) begin
              state_nx  = S_RDATA;
              rd_req_nx = 1'b1;
            end else begin
              state_nx = S_WDATA;
            end
          end
        end
      end
      S_WDATA: begin
        if (cs_q) begin
          state_nx = S_IDLE;
          err_inc  = 1'b1;
        end else begin
          // The pad bit shifts through and falls off the top.
          data_nx = {data[6:0], sdi_q};
          if (slot == SLOT_WDATA_LAST) begin
            wr_en_nx = 1'b1;
            state_nx = S_WAIT;
          end
        end
      end
      S_RDATA: begin
        if (cs_q) begin
          state_nx = S_IDLE;
          err_inc  = 1'b1;
        end else if (slot == SLOT_LAST) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT, S_ERR: begin
        if (cs_q) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      // A frame cut by reset is swallowed silently in WAIT.
      state         <= cs_q ? S_IDLE : S_WAIT;
      rw            <= 1'b0;
      idx           <= '0;
      data          <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_index  <= '0;
      bus.wr_data   <= '0;
      bus.rd_req    <= 1'b0;
      bus.rd_index  <= '0;
      busy          <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      state      <= state_nx;
      rw         <= rw_nx;
      idx        <= idx_nx;
      data       <= data_nx;
      bus.wr_en  <= wr_en_nx;
      bus.rd_req <= rd_req_nx;
      busy       <= (state_nx != S_IDLE);
      if (wr_en_nx) begin
        bus.wr_index <= idx;
        bus.wr_data  <= data_nx;
      end
      if (rd_req_nx) begin
        bus.rd_index <= idx_nx;
      end
      if (err_inc && frame_err_cnt != '1) begin
        frame_err_cnt <= frame_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  logic sdo_sync_load;
  logic sdo_shift;
  logic sdo_data_load;

  assign sdo_sync_load = (cur == S_HDR) && (state_nx == S_RDATA);
  assign sdo_shift     = (cur == S_RDATA) && (state_nx == S_RDATA);
  assign sdo_data_load = sdo_shift && (slot == SLOT_RDATA_LOAD);

  spi_sdo_serializer #(
    .SYNC_PATTERN(SYNC_PATTERN)
  ) u_sdo (
    .clk       (clk_40MHz),
    .rst       (rst),
    .clear     (state_nx != S_RDATA),
    .sync_load (sdo_sync_load),
    .data_load (sdo_data_load),
    .shift     (sdo_shift),
    .rd_data   (bus.rd_data),
    .sdo       (spi_sdo)
  );

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: vector table, scoreboarded strobes,
// back-to-back, saturation and reset-mid-frame sequences.
module tb_spi_cmd_decoder;
  import spi_cfg_pkg::*;

  localparam logic [2:0] SYNC = 3'b101;

  logic       clk;
  logic       rst;
  logic       spi_cs;
  logic       spi_sdi;
  logic       spi_sdo;
  logic [7:0] frame_err_cnt;
  logic       busy;

  spi_cmd_decoder_if bus ();

  spi_cmd_decoder #(
    .SYNC_PATTERN(SYNC),
    .ERR_CNT_W   (8)
  ) dut (
    .clk_40MHz    (clk),
    .rst          (rst),
    .spi_cs       (spi_cs),
    .spi_sdi      (spi_sdi),
    .spi_sdo      (spi_sdo),
    .bus          (bus),
    .frame_err_cnt(frame_err_cnt),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [10:0] wr_q[$];
  logic [2:0]  rd_q[$];
  int          wr_seen = 0;
  int          rd_seen = 0;
  logic        rd_pend = 1'b0;
  logic [7:0]  cur_rdv = 8'h00;
  int          exp_err = 0;

  // Scoreboard: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.wr_en || bus.rd_req)
      chk("wr_rd_excl", 32'(bus.wr_en & bus.rd_req), 0);
    if (bus.wr_en) begin
      logic [10:0] e;
      wr_seen++;
      chk("wr_expected", 32'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        chk("wr_index", 32'(bus.wr_index), 32'(e[10:8]));
        chk("wr_data", 32'(bus.wr_data), 32'(e[7:0]));
      end
    end
    if (bus.rd_req) begin
      rd_seen++;
      rd_pend = 1'b1;
      chk("rd_expected", 32'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0)
        chk("rd_index", 32'(bus.rd_index), 32'(rd_q.pop_front()));
    end
  end

  // Register file model: data valid only in the cycle after rd_req.
  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      bus.rd_data = cur_rdv;
      rd_pend = 1'b0;
    end else begin
      bus.rd_data = ~cur_rdv;
    end
  end

  function automatic logic [15:0] mkf(input logic s, input logic rw,
                                      input logic [2:0] idx,
                                      input logic [7:0] d);
    return {s, rw, idx, 1'b0, d, 2'b00};
  endfunction

  function automatic logic [15:0] exp_sdo(input logic rw,
                                          input logic [7:0] rdv,
                                          input int nbits);
    logic [15:0] r;
    logic [2:0]  sp;
    r  = '0;
    sp = SYNC;
    for (int s = 0; s < 16 && s < nbits; s++) begin
      if (rw && s >= 5 && s <= 7) r[15-s] = sp[7-s];
      else if (rw && s >= 8) r[15-s] = rdv[15-s];
    end
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      spi_cs  = 1'b1;
      spi_sdi = 1'b0;
    end
    @(negedge clk);
  endtask

  // Pin cycle i carries bit i; sdo seen in pin cycle i belongs to slot i-1.
  task automatic send_frame(input logic [15:0] bits, input int nbits,
                            output logic [15:0] sdo_v,
                            output logic [23:0] wr_v,
                            output logic [23:0] rd_v);
    sdo_v = '0;
    wr_v  = '0;
    rd_v  = '0;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk);
      #1;
      spi_cs  = 1'b0;
      spi_sdi = (i < 16) ? bits[15-i] : 1'b1;
      @(negedge clk);
      if (i > 0 && i <= 16) sdo_v[16-i] = spi_sdo;
      wr_v[i] = bus.wr_en;
      rd_v[i] = bus.rd_req;
    end
    @(posedge clk);
    #1;
    spi_cs  = 1'b1;
    spi_sdi = 1'b0;
    @(negedge clk);
    if (nbits <= 16) sdo_v[16-nbits] = spi_sdo;
  endtask

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    logic        rw;
    logic [7:0]  rdv;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
    logic [2:0]  exp_idx;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vt[12];

  task automatic run_vec(input vec_t v, input int k);
    int          w0;
    int          r0;
    logic [15:0] sv;
    logic [23:0] wv;
    logic [23:0] rv;
    w0 = wr_seen;
    r0 = rd_seen;
    if (v.exp_wr != 0) wr_q.push_back({v.exp_idx, v.exp_data});
    if (v.exp_rd != 0) rd_q.push_back(v.exp_idx);
    if (v.exp_err != 0 && exp_err < 255) exp_err++;
    cur_rdv = v.rdv;
    send_frame(v.bits, v.nbits, sv, wv, rv);
    idle(3);
    chk($sformatf("v%0d_wr_cnt", k), wr_seen - w0, v.exp_wr);
    chk($sformatf("v%0d_rd_cnt", k), rd_seen - r0, v.exp_rd);
    chk($sformatf("v%0d_err", k), 32'(frame_err_cnt), exp_err);
    chk($sformatf("v%0d_busy", k), 32'(busy), 0);
    chk($sformatf("v%0d_sdo", k), 32'(sv),
        32'(exp_sdo(v.rw, v.rdv, v.nbits)));
    if (v.exp_wr != 0 && v.nbits >= 16)
      chk($sformatf("v%0d_wr_lat", k), 32'(wv[15]), 1);
    if (v.exp_rd != 0 && v.nbits >= 7)
      chk($sformatf("v%0d_rd_lat", k), 32'(rv[6]), 1);
  endtask

  initial begin
    logic [15:0] sv;
    logic [23:0] wv;
    logic [23:0] rv;
    logic [15:0] bits;
    int          w0;
    vec_t        av;

    vt[0]  = '{mkf(1, 0, IDX_CTRL, 8'hC0), 16, 0, 8'h00, 1, 0, 0, IDX_CTRL, 8'hC0};
    vt[1]  = '{mkf(1, 0, IDX_DAC, 8'h2A), 16, 0, 8'h00, 1, 0, 0, IDX_DAC, 8'h2A};
    vt[2]  = '{mkf(1, 1, IDX_DAC, 8'h00), 16, 1, 8'hA5, 0, 1, 0, IDX_DAC, 8'h00};
    vt[3]  = '{mkf(1, 1, IDX_PUSH, 8'h00), 16, 1, 8'h3C, 0, 1, 0, IDX_PUSH, 8'h00};
    vt[4]  = '{mkf(0, 0, IDX_DAC, 8'h55), 16, 0, 8'h00, 0, 0, 1, 3'b000, 8'h00};
    vt[5]  = '{mkf(1, 0, IDX_CTRL, 8'hC0), 10, 0, 8'h00, 0, 0, 1, 3'b000, 8'h00};
    vt[6]  = '{mkf(1, 1, 3'b010, 8'h00), 8, 1, 8'h99, 0, 1, 1, 3'b010, 8'h00};
    vt[7]  = '{mkf(1, 0, IDX_PUSH, 8'hFF), 16, 0, 8'h00, 1, 0, 0, IDX_PUSH, 8'hFF};
    vt[8]  = '{mkf(1, 1, IDX_CTRL, 8'h00), 5, 1, 8'h66, 0, 1, 1, IDX_CTRL, 8'h00};
    vt[9]  = '{mkf(1, 0, IDX_DAC, 8'h81), 14, 0, 8'h00, 1, 0, 0, IDX_DAC, 8'h81};
    vt[10] = '{mkf(1, 1, IDX_PUSH, 8'h00), 15, 1, 8'hE1, 0, 1, 1, IDX_PUSH, 8'h00};
    vt[11] = '{mkf(1, 0, IDX_PUSH, 8'h81), 20, 0, 8'h00, 1, 0, 0, IDX_PUSH, 8'h81};

    rst     = 1'b1;
    spi_cs  = 1'b1;
    spi_sdi = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_sdo", 32'(spi_sdo), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_index", 32'(bus.wr_index), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    chk("rst_rd_req", 32'(bus.rd_req), 0);
    chk("rst_rd_index", 32'(bus.rd_index), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(frame_err_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    chk("post_rst_busy", 32'(busy), 0);

    for (int k = 0; k < 12; k++) run_vec(vt[k], k);

    // Back-to-back frames, cs high for a single cycle between them.
    w0 = wr_seen;
    for (int f = 0; f < 16; f++) begin
      if (f % 2 == 0) begin
        wr_q.push_back({IDX_DAC, 8'h2A});
        send_frame(mkf(1, 0, IDX_DAC, 8'h2A), 16, sv, wv, rv);
      end else begin
        wr_q.push_back({IDX_PUSH, 8'h00});
        send_frame(mkf(1, 0, IDX_PUSH, 8'h00), 16, sv, wv, rv);
      end
    end
    idle(3);
    chk("b2b_wr_cnt", wr_seen - w0, 16);
    chk("b2b_err", 32'(frame_err_cnt), exp_err);

    // Aborted writes drive the error counter into saturation.
    av = vt[5];
    for (int n = 0; n < 300; n++) run_vec(av, 100 + n);
    chk("sat_err", 32'(frame_err_cnt), 255);
    run_vec(vt[1], 500);

    // Reset in slot 7 of a write while cs stays low.
    bits = mkf(1, 0, IDX_PUSH, 8'hE7);
    w0   = wr_seen;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      spi_cs  = 1'b0;
      spi_sdi = bits[15-i];
      rst     = (i == 8);
      @(negedge clk);
      if (i == 12) begin
        chk("mid_rst_busy", 32'(busy), 1);
        chk("mid_rst_err", 32'(frame_err_cnt), 0);
        chk("mid_rst_sdo", 32'(spi_sdo), 0);
      end
    end
    idle(3);
    exp_err = 0;
    chk("mid_rst_wr_cnt", wr_seen - w0, 0);
    chk("mid_rst_busy_end", 32'(busy), 0);
    chk("mid_rst_err_end", 32'(frame_err_cnt), 0);
    run_vec(vt[0], 600);
    run_vec(vt[2], 601);

    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
